mux_tree_pipelined: RTL and testbench



---
 rtl/mux_tree_pkg.sv | 30 +++
 rtl/mux_tree_pipelined_if.sv | 31 +++
 rtl/mux_tree_level.sv | 60 ++++++
 rtl/mux_tree_pipelined.sv | 85 ++++++++
 tb/tb_mux_tree_pipelined.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
// Imported by the interface, the level sub-module and the top.
package mux_tree_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_NUM_CH = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A tree of 2:1 levels only closes cleanly on a power-of-two channel count.
  function automatic bit num_ch_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  // Guards the package defaults; the top repeats the check for its own parameters.
  localparam bit DEFAULT_NUM_CH_OK = num_ch_ok(DEFAULT_NUM_CH);
  localparam int DEFAULT_CFG_GUARD[1] = '{DEFAULT_NUM_CH_OK ? 0 : -1};

endpackage

// File: rtl/mux_tree_pipelined_if.sv
// Upstream/downstream handshake bundle of the pipelined mux tree.
// 'slave' is the block's view, 'master' is the view of whoever drives it.
interface mux_tree_pipelined_if
  import mux_tree_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int SEL_W  = clog2(NUM_CH)
);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    auto_scan;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_sel, auto_scan, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_sel, auto_scan, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_tree_level.sv
// One registered 2:1 level of the mux tree: halves the node count using
// select bit LEVEL and carries the full select alongside the data.
module mux_tree_level
  import mux_tree_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NODES_IN = DEFAULT_NUM_CH,
  parameter int SEL_W    = clog2(DEFAULT_NUM_CH),
  parameter int LEVEL    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_adv,
  input  logic                            i_valid,
  input  logic [SEL_W-1:0]                i_sel,
  input  logic [NODES_IN*WIDTH-1:0]       i_nodes,
  output logic                            o_valid,
  output logic [SEL_W-1:0]                o_sel,
  output logic [(NODES_IN/2)*WIDTH-1:0]   o_nodes
);

  localparam int NODES_OUT = NODES_IN / 2;

  logic [NODES_OUT*WIDTH-1:0] w_nodes_nxt;
  logic [NODES_OUT*WIDTH-1:0] r_nodes;
  logic [SEL_W-1:0]           r_sel;
  logic                       r_valid;

  always_comb begin
    // NOTE: assign a default before the loop so every bit is written on every
    // pass through the block; a partially assigned signal infers a latch.
    w_nodes_nxt = '0;
    for (int j = 0; j < NODES_OUT; j++) begin
      w_nodes_nxt[j*WIDTH +: WIDTH] = i_sel[LEVEL] ? i_nodes[(2*j+1)*WIDTH +: WIDTH]
                                                   : i_nodes[(2*j)*WIDTH +: WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  // NOTE: these are a handful of pipeline flops, not a memory array, so data and
  // select are reset as well; a reset value costs little here and keeps out_data
  // deterministic after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_nodes <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_sel   <= i_sel;
      r_nodes <= w_nodes_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_sel   = r_sel;
  assign o_nodes = r_nodes;

endmodule

// File: rtl/mux_tree_pipelined.sv
// Pipelined NUM_CH:1 multiplexer: LEVELS registered 2:1 levels sharing one
// advance enable, with valid/ready backpressure and a round-robin auto-scan select.
module mux_tree_pipelined
  import mux_tree_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = DEFAULT_NUM_CH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_tree_pipelined_if.slave   bus
);

  localparam int SEL_W  = clog2(NUM_CH);
  localparam int LEVELS = SEL_W;
  localparam logic [SEL_W-1:0] SCAN_STEP = SEL_W'(1);

  if (!num_ch_ok(NUM_CH) || (WIDTH < 1)) begin : g_bad_cfg
    $error("mux_tree_pipelined: NUM_CH must be a power of two >= 2 and WIDTH >= 1");
  end

  logic             w_adv;
  logic             w_accept;
  logic [SEL_W-1:0] w_esel;
  logic [SEL_W-1:0] r_scan_cnt;

  // The pipe moves as one: it advances whenever the output slot is free or draining.
  assign w_adv       = bus.out_ready | ~bus.out_valid;
  assign w_accept    = bus.in_valid & w_adv;
  assign w_esel      = bus.auto_scan ? r_scan_cnt : bus.in_sel;
  assign bus.in_ready = w_adv;

  // Power-of-two channel count means the natural wrap of the counter is the
  // NUM_CH-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
    end else if (w_accept && bus.auto_scan) begin
      r_scan_cnt <= r_scan_cnt + SCAN_STEP;
    end
  end

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int NODES_IN = NUM_CH >> i;

    logic [NODES_IN*WIDTH-1:0]     w_nodes_in;
    logic                          w_valid_in;
    logic [SEL_W-1:0]              w_sel_in;
    logic [(NODES_IN/2)*WIDTH-1:0] w_nodes_out;
    logic                          w_valid_out;
    logic [SEL_W-1:0]              w_sel_out;

    if (i == 0) begin : g_head
      assign w_nodes_in = bus.in_data;
      assign w_valid_in = w_accept;
      assign w_sel_in   = w_esel;
    end else begin : g_link
      assign w_nodes_in = g_lvl[i-1].w_nodes_out;
      assign w_valid_in = g_lvl[i-1].w_valid_out;
      assign w_sel_in   = g_lvl[i-1].w_sel_out;
    end

    mux_tree_level #(
      .WIDTH    (WIDTH),
      .NODES_IN (NODES_IN),
      .SEL_W    (SEL_W),
      .LEVEL    (i)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_valid (w_valid_in),
      .i_sel   (w_sel_in),
      .i_nodes (w_nodes_in),
      .o_valid (w_valid_out),
      .o_sel   (w_sel_out),
      .o_nodes (w_nodes_out)
    );
  end

  assign bus.out_data  = g_lvl[LEVELS-1].w_nodes_out;
  assign bus.out_ch    = g_lvl[LEVELS-1].w_sel_out;
  assign bus.out_valid = g_lvl[LEVELS-1].w_valid_out;

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Directed bench for mux_tree_pipelined: latency, streaming, backpressure,
// auto-scan, mid-flight reset (8x8-bit) and the minimum 2x1-bit configuration.
module tb_mux_tree_pipelined;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_tree_pipelined_if #(.WIDTH(8), .NUM_CH(8)) bus8 ();
  mux_tree_pipelined_if #(.WIDTH(1), .NUM_CH(2)) bus2 ();

  mux_tree_pipelined #(.WIDTH(8), .NUM_CH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  mux_tree_pipelined #(.WIDTH(1), .NUM_CH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q_data[$];
  int         q_ch[$];
  int         q_t[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic flush();
    q_data.delete();
    q_ch.delete();
    q_t.delete();
  endtask

  // Called just after a falling edge with inputs set; samples before the rising edge.
  task automatic tick(output bit acc);
    #1;
    acc = bus8.in_valid && bus8.in_ready;
    if (bus8.out_valid && bus8.out_ready) begin
      q_data.push_back(bus8.out_data);
      q_ch.push_back(int'(bus8.out_ch));
      q_t.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_words(input string tag, input int exp[$]);
    check({tag, "_cnt"}, q_ch.size(), exp.size());
    for (int k = 0; k < exp.size() && k < q_ch.size(); k++) begin
      check($sformatf("%s_ch%0d", tag, k), q_ch[k], exp[k]);
      check($sformatf("%s_data%0d", tag, k), q_data[k], 32'(16 + exp[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int t_first;
    int n_acc;
    int idx;
    int rel;
    int exp_seq[$];

    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) bus8.in_data[k*8 +: 8] = 8'(16 + k);
    bus8.in_sel    = '0;
    bus8.auto_scan = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    bus2.in_data   = 2'b10;
    bus2.in_sel    = '0;
    bus2.auto_scan = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_out_data",  bus8.out_data,  0);
    check("rst_out_ch",    bus8.out_ch,    0);
    check("rst_in_ready",  bus8.in_ready,  1);
    check("rst2_out_valid", bus2.out_valid, 0);
    @(negedge clk);

    // Latency: one word, channel 5
    flush();
    bus8.in_sel   = 3'd5;
    bus8.in_valid = 1'b1;
    t_first = cyc;
    tick(acc);
    check("lat_accept", acc, 1);
    bus8.in_valid = 1'b0;
    repeat (7) tick(acc);
    check("lat_cnt", q_t.size(), 1);
    if (q_t.size() > 0) begin
      check("lat_cycles", q_t[0] - t_first, 3);
      check("lat_data", q_data[0], 8'h15);
      check("lat_ch", q_ch[0], 5);
    end

    // Streaming: channels 0..7 back to back
    flush();
    n_acc = 0;
    t_first = cyc;
    for (int i = 0; i < 8; i++) begin
      bus8.in_sel   = 3'(i);
      bus8.in_valid = 1'b1;
      tick(acc);
      if (acc) n_acc++;
    end
    bus8.in_valid = 1'b0;
    repeat (6) tick(acc);
    check("stream_acc", n_acc, 8);
    exp_seq = {0, 1, 2, 3, 4, 5, 6, 7};
    check_words("stream", exp_seq);
    for (int k = 0; k < q_t.size(); k++)
      check($sformatf("stream_t%0d", k), q_t[k] - t_first, 3 + k);

    // Backpressure: out_ready low for 4 cycles while word 2 sits at the output
    flush();
    idx = 0;
    rel = 0;
    while (idx < 8 && rel < 40) begin
      bus8.in_sel    = 3'(idx);
      bus8.in_valid  = 1'b1;
      bus8.out_ready = !(rel >= 5 && rel <= 8);
      if (!bus8.out_ready) begin
        #1;
        check($sformatf("bp_in_ready%0d", rel), bus8.in_ready, 0);
        check($sformatf("bp_valid%0d", rel), bus8.out_valid, 1);
        check($sformatf("bp_hold_data%0d", rel), bus8.out_data, 8'h12);
        check($sformatf("bp_hold_ch%0d", rel), bus8.out_ch, 2);
      end
      tick(acc);
      if (acc) idx++;
      rel++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (10) tick(acc);
    check("bp_all_accepted", idx, 8);
    exp_seq = {0, 1, 2, 3, 4, 5, 6, 7};
    check_words("bp", exp_seq);

    // Auto-scan: 10 scanned words with bubbles and a stall, then one manual
    // word (sel 6) and one more scanned word to show the count was kept.
    flush();
    idx = 0;
    rel = 0;
    while (idx < 12 && rel < 80) begin
      bus8.auto_scan = (idx != 10);
      bus8.in_sel    = (idx == 10) ? 3'd6 : 3'd3;
      bus8.in_valid  = (rel % 5 != 3);
      bus8.out_ready = !(rel >= 6 && rel <= 7);
      tick(acc);
      if (acc) idx++;
      rel++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (10) tick(acc);
    exp_seq = {0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 6, 2};
    check_words("scan", exp_seq);

    // Reset with two words in flight, first one parked at the output
    flush();
    bus8.auto_scan = 1'b1;
    bus8.in_valid  = 1'b1;
    tick(acc);
    tick(acc);
    bus8.in_valid = 1'b0;
    tick(acc);
    bus8.out_ready = 1'b0;
    #1;
    check("rstmid_pre_valid", bus8.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", bus8.out_valid, 0);
    check("rstmid_data",  bus8.out_data,  0);
    check("rstmid_ready", bus8.in_ready,  1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush();
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    tick(acc);
    tick(acc);
    bus8.in_valid = 1'b0;
    repeat (8) tick(acc);
    exp_seq = {0, 1};
    check_words("rst_after", exp_seq);

    // Minimum configuration: 2 channels of 1 bit, latency 1
    bus8.auto_scan = 1'b0;
    bus2.in_sel    = 1'b0;
    bus2.in_valid  = 1'b1;
    #1;
    check("min_in_ready", bus2.in_ready, 1);
    check("min_idle_valid", bus2.out_valid, 0);
    @(negedge clk);
    bus2.in_sel = 1'b1;
    #1;
    check("min_valid0", bus2.out_valid, 1);
    check("min_data0",  bus2.out_data,  0);
    check("min_ch0",    bus2.out_ch,    0);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    #1;
    check("min_valid1", bus2.out_valid, 1);
    check("min_data1",  bus2.out_data,  1);
    check("min_ch1",    bus2.out_ch,    1);
    @(negedge clk);
    #1;
    check("min_drained", bus2.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
